// File: rtl/timer_pkg.sv
// timer_pkg: shared definitions for the memory-mapped timer peripheral.
// Holds the register offsets decoded from A[2:0], the CTRL bit positions
// and the sequencing FSM state type used by timer_ctrl.
package timer_pkg;

    // Register offsets (word address bits [2:0])
    localparam logic [2:0] TMR_CTRL   = 3'd0;
    localparam logic [2:0] TMR_LOAD   = 3'd1;
    localparam logic [2:0] TMR_COUNT  = 3'd2;
    localparam logic [2:0] TMR_PRESC  = 3'd3;
    localparam logic [2:0] TMR_STATUS = 3'd4;

    // CTRL register bit positions
    localparam int EN_BIT   = 0;
    localparam int MODE_BIT = 1;
    localparam int IE_BIT   = 2;

    // STATUS register bit positions
    localparam int TF_BIT   = 0;

    // Sequencing FSM states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RELOAD = 2'd1,
        RUN    = 2'd2
    } timer_state_t;

    // True when a bus write targets the given register offset
    function automatic logic regWrite(input logic       we,
                                      input logic [2:0] addr,
                                      input logic [2:0] offset);
        return we && (addr == offset);
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler: divides the clock by (presc + 1) while the timer runs.
// tick is a one-cycle pulse asserted in the cycle where the internal
// counter equals presc; the counter restarts from 0 on that same edge.
module timer_prescaler #(
    parameter int PRESC_W = 16
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               clr,
    input  logic               run,
    input  logic [PRESC_W-1:0] presc,
    output logic               tick
);

    localparam logic [PRESC_W-1:0] PRESC_ONE = PRESC_W'(1);

    logic [PRESC_W-1:0] r_cnt;
    logic               w_hit;

    assign w_hit = (r_cnt == presc);
    assign tick  = run && w_hit;

    // Count cycles while running; a clear or a tick restarts the count at 0
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (run) begin
            if (w_hit) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + PRESC_ONE;
            end
        end
    end

endmodule

// File: rtl/timer_ctrl.sv
// timer_ctrl: programmable down-counting timer on the CPU load/store bus.
// Holds CTRL/LOAD/COUNT/PRESC/STATUS, sequences them with an
// IDLE -> RELOAD -> RUN FSM and raises a level IRQ on expiry.
// On simultaneous events a bus write to COUNT or a CTRL write clearing EN
// takes priority over the prescaler tick, while a new expiry beats a
// write-1-to-clear of TF.
module timer_ctrl
    import timer_pkg::*;
#(
    parameter int PRESC_W = 16,
    parameter int CNT_W   = 32
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [9:0]  A,
    input  logic [31:0] WD,
    input  logic        WE,
    output logic [31:0] RD,
    output logic        IRQ
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    timer_state_t       r_state;
    timer_state_t       w_nextState;

    logic [2:0]         r_ctrl;
    logic [CNT_W-1:0]   r_load;
    logic [CNT_W-1:0]   r_count;
    logic [PRESC_W-1:0] r_presc;
    logic               r_tf;
    logic [31:0]        r_rd;

    logic [2:0]         w_addr;
    logic               w_wrCtrl;
    logic               w_wrLoad;
    logic               w_wrCount;
    logic               w_wrPresc;
    logic               w_wrStatus;
    logic               w_stopWr;
    logic               w_running;
    logic               w_reloading;
    logic               w_tick;
    logic               w_tickAct;
    logic               w_expire;
    logic               w_oneShotDone;
    logic               w_presClr;
    logic [31:0]        w_rdData;
    logic               w_unusedAddr;

    // Only the low three address bits select a register
    assign w_addr       = A[2:0];
    assign w_unusedAddr = ^A[9:3];

    assign w_wrCtrl   = regWrite(WE, w_addr, TMR_CTRL);
    assign w_wrLoad   = regWrite(WE, w_addr, TMR_LOAD);
    assign w_wrCount  = regWrite(WE, w_addr, TMR_COUNT);
    assign w_wrPresc  = regWrite(WE, w_addr, TMR_PRESC);
    assign w_wrStatus = regWrite(WE, w_addr, TMR_STATUS);

    // A CTRL write with EN=0 stops the timer and suppresses a coincident tick
    assign w_stopWr    = w_wrCtrl && !WD[EN_BIT];
    assign w_running   = (r_state == RUN);
    assign w_reloading = (r_state == RELOAD);

    // A tick only acts on COUNT when no higher-priority write is in flight
    assign w_tickAct     = w_running && w_tick && !w_wrCount && !w_stopWr;
    assign w_expire      = w_tickAct && (r_count == '0);
    assign w_oneShotDone = w_expire && !r_ctrl[MODE_BIT];

    // Prescaler restarts on reload and whenever software rewrites COUNT in RUN
    assign w_presClr = w_reloading || (w_running && w_wrCount);

    timer_prescaler #(
        .PRESC_W (PRESC_W)
    ) u_prescaler (
        .CLK   (CLK),
        .RST   (RST),
        .clr   (w_presClr),
        .run   (w_running),
        .presc (r_presc),
        .tick  (w_tick)
    );

    // FSM state register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // FSM next-state logic: enable starts a reload, disable or one-shot expiry returns to IDLE
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (w_wrCtrl && WD[EN_BIT]) begin
                    w_nextState = RELOAD;
                end
            end
            RELOAD: begin
                if (w_stopWr) begin
                    w_nextState = IDLE;
                end else begin
                    w_nextState = RUN;
                end
            end
            RUN: begin
                if (w_stopWr) begin
                    w_nextState = IDLE;
                end else if (w_oneShotDone && !w_wrCtrl) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // CTRL: software writes win; a one-shot expiry clears EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_ctrl <= '0;
        end else if (w_wrCtrl) begin
            r_ctrl <= WD[2:0];
        end else if (w_oneShotDone) begin
            r_ctrl[EN_BIT] <= 1'b0;
        end
    end

    // LOAD and PRESC are plain software registers, sampled at the next reload/tick
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_load  <= '0;
            r_presc <= '0;
        end else begin
            if (w_wrLoad) begin
                r_load <= WD[CNT_W-1:0];
            end
            if (w_wrPresc) begin
                r_presc <= WD[PRESC_W-1:0];
            end
        end
    end

    // COUNT: write beats reload beats tick; expiry reloads only in periodic mode
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_count <= '0;
        end else if (w_wrCount) begin
            r_count <= WD[CNT_W-1:0];
        end else if (w_reloading) begin
            r_count <= r_load;
        end else if (w_tickAct) begin
            if (r_count != '0) begin
                r_count <= r_count - CNT_ONE;
            end else if (r_ctrl[MODE_BIT]) begin
                r_count <= r_load;
            end
        end
    end

    // STATUS.TF: set on expiry (which wins), cleared by writing 1
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_tf <= 1'b0;
        end else if (w_expire) begin
            r_tf <= 1'b1;
        end else if (w_wrStatus && WD[TF_BIT]) begin
            r_tf <= 1'b0;
        end
    end

    // Read mux over current register contents; unmapped offsets return 0
    always_comb begin
        w_rdData = '0;
        case (w_addr)
            TMR_CTRL:   w_rdData[2:0]         = r_ctrl;
            TMR_LOAD:   w_rdData[CNT_W-1:0]   = r_load;
            TMR_COUNT:  w_rdData[CNT_W-1:0]   = r_count;
            TMR_PRESC:  w_rdData[PRESC_W-1:0] = r_presc;
            TMR_STATUS: w_rdData[TF_BIT]      = r_tf;
            default:    w_rdData              = '0;
        endcase
    end

    // Registered read data, one cycle after the address is sampled
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_rd <= '0;
        end else begin
            r_rd <= w_rdData;
        end
    end

    assign RD  = r_rd;
    assign IRQ = r_tf & r_ctrl[IE_BIT];

endmodule

// File: tb/tb_timer_ctrl.sv
// tb_timer_ctrl: self-checking bench for timer_ctrl.
// A register-level behavioural model tracks what every register must hold
// after each clock edge; RD and IRQ are compared against it on every
// falling edge. Directed sequences pin exact latencies and readback values
// with hand-computed constants, then a randomized phase exercises the
// priority rules between bus writes and timer events.
module tb_timer_ctrl;

    localparam int S_IDLE   = 0;
    localparam int S_RELOAD = 1;
    localparam int S_RUN    = 2;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [9:0]  A   = '0;
    logic [31:0] WD  = '0;
    logic        WE  = 1'b0;
    logic [31:0] RD;
    logic        IRQ;

    int checks = 0;
    int errors = 0;
    bit checkOn = 1'b0;

    // Behavioural model of the programmer-visible state
    int          mState;
    logic [2:0]  mCtrl;
    logic [31:0] mLoad;
    logic [31:0] mCount;
    logic [15:0] mPresc;
    logic [15:0] mPcnt;
    bit          mTf;
    logic [31:0] mRd;

    timer_ctrl #(
        .PRESC_W (16),
        .CNT_W   (32)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .A   (A),
        .WD  (WD),
        .WE  (WE),
        .RD  (RD),
        .IRQ (IRQ)
    );

    // 10-time-unit clock
    always #5 CLK = ~CLK;

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic resetModel();
        mState = S_IDLE;
        mCtrl  = '0;
        mLoad  = '0;
        mCount = '0;
        mPresc = '0;
        mPcnt  = '0;
        mTf    = 1'b0;
        mRd    = '0;
    endtask

    // Advance the model by one clock edge given the bus cycle presented at that edge
    task automatic modelStep(input logic we, input logic [9:0] a, input logic [31:0] wd);
        logic [2:0]  off;
        bit          wrCtrl, wrLoad, wrCount, wrPresc, wrStatus;
        bit          stopWr, tick, expire, oneShot;
        int          nState;
        logic [2:0]  nCtrl;
        logic [31:0] nLoad, nCount, nRd;
        logic [15:0] nPresc, nPcnt;
        bit          nTf;

        off      = a[2:0];
        wrCtrl   = we && (off == 3'd0);
        wrLoad   = we && (off == 3'd1);
        wrCount  = we && (off == 3'd2);
        wrPresc  = we && (off == 3'd3);
        wrStatus = we && (off == 3'd4);

        case (off)
            3'd0:    nRd = {29'd0, mCtrl};
            3'd1:    nRd = mLoad;
            3'd2:    nRd = mCount;
            3'd3:    nRd = {16'd0, mPresc};
            3'd4:    nRd = {31'd0, mTf};
            default: nRd = 32'd0;
        endcase

        tick    = (mState == S_RUN) && (mPcnt == mPresc);
        stopWr  = wrCtrl && !wd[0];
        oneShot = !mCtrl[1];
        expire  = tick && !wrCount && !stopWr && (mCount == 32'd0);

        nCount = mCount;
        if (wrCount)
            nCount = wd;
        else if (mState == S_RELOAD)
            nCount = mLoad;
        else if (tick && !stopWr)
            nCount = (mCount != 0) ? mCount - 32'd1 : (oneShot ? 32'd0 : mLoad);

        nPcnt = mPcnt;
        if (mState == S_RELOAD || (mState == S_RUN && wrCount))
            nPcnt = 16'd0;
        else if (mState == S_RUN)
            nPcnt = tick ? 16'd0 : mPcnt + 16'd1;

        nTf = expire ? 1'b1 : ((wrStatus && wd[0]) ? 1'b0 : mTf);

        if (wrCtrl)
            nCtrl = wd[2:0];
        else if (expire && oneShot)
            nCtrl = {mCtrl[2:1], 1'b0};
        else
            nCtrl = mCtrl;

        nState = mState;
        if (mState == S_IDLE)
            nState = (wrCtrl && wd[0]) ? S_RELOAD : S_IDLE;
        else if (mState == S_RELOAD)
            nState = stopWr ? S_IDLE : S_RUN;
        else if (stopWr || (expire && oneShot && !wrCtrl))
            nState = S_IDLE;

        nLoad  = wrLoad ? wd : mLoad;
        nPresc = wrPresc ? wd[15:0] : mPresc;

        mState = nState;
        mCtrl  = nCtrl;
        mLoad  = nLoad;
        mCount = nCount;
        mPresc = nPresc;
        mPcnt  = nPcnt;
        mTf    = nTf;
        mRd    = nRd;
    endtask

    task automatic checkOutput();
        checkValue("rd", RD, mRd);
        checkValue("irq", {31'd0, IRQ}, {31'd0, mTf & mCtrl[2]});
    endtask

    // Compare DUT outputs with the model on every falling edge
    always @(negedge CLK) begin
        if (checkOn) checkOutput();
    end

    // One bus cycle: drive at the falling edge, step the model at the rising edge
    task automatic applyStimulus(input logic we, input logic [9:0] a, input logic [31:0] wd);
        WE = we;
        A  = a;
        WD = wd;
        @(posedge CLK);
        modelStep(we, a, wd);
        @(negedge CLK);
    endtask

    task automatic writeReg(input logic [2:0] addr, input logic [31:0] data);
        applyStimulus(1'b1, {7'($urandom), addr}, data);
    endtask

    task automatic readReg(input logic [2:0] addr);
        applyStimulus(1'b0, {7'($urandom), addr}, 32'd0);
    endtask

    // Count edges until IRQ is seen high, starting from a given edge count
    task automatic waitIrq(input string name, input int expCycles, input int start);
        int k;
        bit seen;
        k = start;
        seen = 1'b0;
        while (!seen && k < 200) begin
            applyStimulus(1'b0, 10'($urandom_range(0, 1023)), 32'd0);
            k++;
            if (IRQ) seen = 1'b1;
        end
        checkValue(name, k, expCycles);
    endtask

    // Watchdog so the run always ends
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int r;
        logic [2:0]  addr;
        logic [31:0] data;

        resetModel();
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        checkOn = 1'b1;
        checkValue("reset_rd", RD, 32'd0);
        checkValue("reset_irq", {31'd0, IRQ}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            readReg(3'(i));
            checkValue($sformatf("reset_reg%0d", i), RD, 32'd0);
        end

        // One-shot: LOAD=3, PRESC=0, EN|IE -> expiry 5 edges after enable
        $display("[TB] one-shot");
        writeReg(3'd1, 32'd3);
        writeReg(3'd3, 32'd0);
        writeReg(3'd0, 32'h5);
        waitIrq("oneshot_latency", 5, 0);
        readReg(3'd0);
        checkValue("oneshot_ctrl", RD, 32'h4);
        readReg(3'd2);
        checkValue("oneshot_count", RD, 32'd0);
        repeat (20) readReg(3'($urandom_range(0, 7)));
        writeReg(3'd4, 32'd1);
        repeat (20) readReg(3'($urandom_range(0, 7)));
        readReg(3'd4);
        checkValue("oneshot_no_reexpire", RD, 32'd0);

        // Periodic with prescale: LOAD=2, PRESC=3 -> 13 then every 12
        $display("[TB] periodic");
        writeReg(3'd1, 32'd2);
        writeReg(3'd3, 32'd3);
        writeReg(3'd0, 32'h7);
        waitIrq("periodic_first", 13, 0);
        for (int i = 0; i < 4; i++) begin
            writeReg(3'd4, 32'd1);
            waitIrq($sformatf("periodic_period%0d", i), 12, 1);
        end
        writeReg(3'd0, 32'd0);
        writeReg(3'd4, 32'd1);

        // W1C on the same edge as an expiry: TF must stay set
        $display("[TB] w1c collision");
        writeReg(3'd1, 32'd1);
        writeReg(3'd3, 32'd0);
        writeReg(3'd0, 32'h7);
        readReg(3'd0);
        readReg(3'd0);
        writeReg(3'd4, 32'd1);
        checkValue("w1c_collide_irq", {31'd0, IRQ}, 32'd1);
        writeReg(3'd0, 32'h4);
        readReg(3'd4);
        checkValue("w1c_collide_tf", RD, 32'd1);
        writeReg(3'd4, 32'd1);
        checkValue("w1c_clear_irq", {31'd0, IRQ}, 32'd0);

        // COUNT written in RUN: next decrement PRESC+1 edges later
        $display("[TB] mid-run count write");
        writeReg(3'd1, 32'd20);
        writeReg(3'd3, 32'd2);
        writeReg(3'd0, 32'h1);
        repeat (5) readReg(3'd0);
        writeReg(3'd2, 32'd10);
        readReg(3'd2);
        checkValue("count_w1", RD, 32'd10);
        readReg(3'd2);
        checkValue("count_w2", RD, 32'd10);
        readReg(3'd2);
        checkValue("count_w3", RD, 32'd10);
        readReg(3'd2);
        checkValue("count_w4", RD, 32'd9);
        writeReg(3'd0, 32'd0);

        // LOAD written mid-run affects only the next reload
        $display("[TB] mid-run load write");
        writeReg(3'd1, 32'd2);
        writeReg(3'd3, 32'd0);
        writeReg(3'd0, 32'h7);
        writeReg(3'd1, 32'd5);
        waitIrq("load_current", 4, 1);
        writeReg(3'd4, 32'd1);
        waitIrq("load_next", 6, 1);
        writeReg(3'd0, 32'd0);
        writeReg(3'd4, 32'd1);

        // Disable while COUNT=4 freezes it
        $display("[TB] disable freeze");
        writeReg(3'd1, 32'd8);
        writeReg(3'd0, 32'h5);
        repeat (5) readReg(3'd4);
        writeReg(3'd0, 32'd0);
        repeat (10) readReg(3'($urandom_range(0, 7)));
        readReg(3'd2);
        checkValue("freeze_count", RD, 32'd4);
        readReg(3'd4);
        checkValue("freeze_tf", RD, 32'd0);
        checkValue("freeze_irq", {31'd0, IRQ}, 32'd0);

        // Unmapped offsets and read latency
        $display("[TB] readback");
        for (int i = 5; i < 8; i++) writeReg(3'(i), 32'hFFFF_FFFF);
        for (int i = 5; i < 8; i++) begin
            readReg(3'(i));
            checkValue($sformatf("unmapped%0d", i), RD, 32'd0);
        end
        writeReg(3'd2, 32'h55);
        writeReg(3'd3, 32'h1234);
        readReg(3'd5);
        checkValue("latency_pre", RD, 32'd0);
        readReg(3'd2);
        checkValue("latency_count", RD, 32'h55);
        readReg(3'd3);
        checkValue("latency_presc", RD, 32'h1234);

        // Asynchronous reset in the middle of RUN
        $display("[TB] reset mid-run");
        writeReg(3'd3, 32'd0);
        writeReg(3'd1, 32'd0);
        writeReg(3'd0, 32'h7);
        readReg(3'd0);
        readReg(3'd0);
        checkValue("prerst_irq", {31'd0, IRQ}, 32'd1);
        writeReg(3'd3, 32'd100);
        writeReg(3'd2, 32'd7);
        readReg(3'd2);
        checkValue("prerst_count", RD, 32'd7);
        checkOn = 1'b0;
        #2;
        RST = 1'b1;
        resetModel();
        #1;
        checkValue("rst_rd", RD, 32'd0);
        checkValue("rst_irq", {31'd0, IRQ}, 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        checkOn = 1'b1;
        for (int i = 0; i < 8; i++) begin
            readReg(3'(i));
            checkValue($sformatf("postrst_reg%0d", i), RD, 32'd0);
        end
        repeat (30) readReg(3'($urandom_range(0, 7)));
        checkValue("postrst_irq", {31'd0, IRQ}, 32'd0);

        // Randomized traffic checked cycle by cycle against the model
        $display("[TB] random phase");
        for (int n = 0; n < 800; n++) begin
            r = $urandom_range(0, 99);
            if (r < 55) begin
                readReg(3'($urandom_range(0, 7)));
            end else begin
                addr = 3'($urandom_range(0, 7));
                data = $urandom;
                case (addr)
                    3'd0: data[0] = ($urandom_range(0, 9) < 8);
                    3'd1: data = 32'($urandom_range(0, 6));
                    3'd2: data = 32'($urandom_range(0, 8));
                    3'd3: data = 32'($urandom_range(0, 3));
                    default: ;
                endcase
                if (addr == 3'd3 && mState != S_IDLE)
                    readReg(addr);
                else
                    writeReg(addr, data);
            end
        end

        checkOn = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/timer_ctrl.md
# timer_ctrl

Programmable down-counting timer controller for the SoC's memory-mapped timer peripheral. It sits on the same CPU load/store bus as the other peripherals (word address `A`, `WD`, `WE`, `RD`). It holds the control, reload, count, prescale and status registers, and sequences them with a small FSM. It raises `IRQ` toward the MIPS core on expiry.

## Interface
- `PRESC_W`, default 16: prescaler register and counter width.
- `CNT_W`, default 32: LOAD/COUNT width; must be ≤ 32.
- `CLK` input, 1 bit: single clock, rising edge.
- `RST` input, 1 bit: reset, asynchronous and active-high.
- `A` input, 10 bits: word address. Only `A[2:0]` is decoded; `A[9:3]` is ignored.
- `WD` input, 32 bits: write data. Writes are full-word only; store formatting is done upstream.
- `WE` input, 1 bit: write strobe, sampled at the rising edge.
- `RD` output, 32 bits: registered read data.
- `IRQ` output, 1 bit: level interrupt, equal to `STATUS.TF & CTRL.IE`.

## Operation
- Register map (`A[2:0]`):
  - 0 CTRL: bit0 EN, bit1 MODE (0 = one-shot, 1 = periodic), bit2 IE.
  - 1 LOAD.
  - 2 COUNT (read/write).
  - 3 PRESC.
  - 4 STATUS: bit0 TF, write-1-to-clear.
  - 5–7: read 0; writes are ignored.
- Reset values: all registers 0; `RD` = 0; `IRQ` = 0; FSM in IDLE; prescaler counter 0.
- FSM states: IDLE, RELOAD, RUN.
  - IDLE → RELOAD: on a CTRL write with EN=1. A COUNT write while in IDLE loads COUNT and stays in IDLE.
  - RELOAD (one cycle): COUNT ← LOAD, prescaler counter ← 0, then → RUN.
  - RUN → IDLE: on a CTRL write with EN=0. COUNT is retained.
- Prescaler (RUN only):
  - Counter increments each cycle.
  - When counter == PRESC, it emits a one-cycle `tick` and the counter returns to 0.
  - Result: one tick every PRESC+1 cycles.
- On `tick` in RUN:
  - If COUNT ≠ 0: COUNT ← COUNT − 1.
  - If COUNT == 0: TF ← 1. Then, if periodic, COUNT ← LOAD and stay in RUN. If one-shot, EN ← 0 and go to IDLE.
- A COUNT write in RUN loads COUNT and clears the prescaler counter.
- A LOAD write affects only the next reload.
- Simultaneous events:
  - TF set and a W1C on the same edge: TF ends at 1 (set wins).
  - CTRL EN=0 write and a tick on the same edge: the write wins; no decrement and no TF.
  - COUNT write and a tick on the same edge: the write wins.
- Arithmetic: COUNT decrement is unsigned and never wraps below 0; expiry reloads it instead.
- LOAD = 0 in periodic mode expires on every tick.
- Reads return the current value of the addressed register; COUNT reads include the live value.
- `RST` during RUN: the block returns to IDLE immediately and all state resets.

## Timing
- Read latency is 1 cycle: `A` sampled at edge N, `RD` valid after edge N, held until the next edge.
- Register writes take effect at the sampling edge.
- CTRL EN=1 written at edge E0:
  - RELOAD at E0+1.
  - First expiry (TF=1) at edge E0 + 1 + (LOAD+1)(PRESC+1).
- Periodic mode: subsequent expiries every (LOAD+1)(PRESC+1) cycles. No dead cycle at reload.
- `IRQ` is derived from registered state, so it is glitch-free. It rises in the same cycle TF becomes 1.

## Structure
- `timer_pkg` holds:
  - register offsets `TMR_CTRL`…`TMR_STATUS`;
  - CTRL bit indices `EN_BIT`, `MODE_BIT`, `IE_BIT`;
  - the FSM state enum `{IDLE, RELOAD, RUN}`.
- One sub-module, `timer_prescaler`. Inputs: `CLK`, `RST`, `clr`, `run`, `presc`. Output: one-cycle `tick`.
- Register file, FSM and read mux live in `timer_ctrl`.

## Test plan
- **Reset:** assert `RST` mid-RUN with COUNT=7 → all registers 0, `RD`=0, `IRQ`=0, FSM in IDLE within the same cycle; no TF afterwards.
- **One-shot:** LOAD=3, PRESC=0, CTRL=0x5 (EN, IE, one-shot) at E0 → TF and `IRQ` at E0+5, CTRL reads 0x4, COUNT reads 0, no further expiries.
- **Periodic with prescale:** LOAD=2, PRESC=3, CTRL=0x3 → first TF at E0+13. W1C STATUS, then TF again exactly 12 cycles later; repeat 4 times.
- **W1C collision:** write STATUS=1 on the same edge as an expiry → TF reads 1; a second W1C clears it and `IRQ` drops.
- **Mid-run writes:**
  - COUNT=10 written in RUN → next decrement occurs PRESC+1 cycles later, to 9.
  - LOAD=5 written → current period unchanged; the next reload uses 5.
- **Disable and readback:**
  - CTRL=0 while COUNT=4 → COUNT frozen at 4, no TF.
  - Unmapped addresses 5–7 read 0.
  - `RD` appears one cycle after `A`.
